// File: rtl/mulu_add_int.sv
// ----------------------------------------------------------------------------
// mulu_add_int
//   Iterative unsigned multiply-add: val = a*b + c, one shift-add step per
//   clock. Companion to the iterative unsigned divider: feeding back divisor,
//   quotient and remainder rebuilds the dividend. Uses the same
//   start/busy/done/valid handshake as the divider.
//
// Configuration macro:
//   MULU_EARLY_EXIT_EN  when defined, completes as soon as the remaining
//                       multiplier bits are all zero. Results are unchanged;
//                       only latency shrinks.
//
// Ports:
//   clk    in   1         clock, rising edge
//   rst_n  in   1         asynchronous active-low reset
//   start  in   1         start; a/b/c sampled on the same edge
//   busy   out  1         calculation in progress
//   done   out  1         one-cycle completion pulse
//   valid  out  1         val/ovf hold the last completed result
//   ovf    out  1         result does not fit in WIDTH bits
//   a      in   WIDTH     multiplicand
//   b      in   WIDTH     multiplier
//   c      in   WIDTH     addend
//   val    out  2*WIDTH   result a*b + c
// ----------------------------------------------------------------------------
module mulu_add_int #(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               valid,
    output logic               ovf,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic [2*WIDTH-1:0] val
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplr;
    logic [CW-1:0]      cnt;

    logic [2*WIDTH-1:0] acc_next;
    logic               last;

    // 2*WIDTH bits hold the worst case (2^W-1)^2 + 2^W-1 = 2^2W - 2^W, so the
    // addition never carries out.
    always_comb begin
        acc_next = acc + (mplr[0] ? mcand : '0);
`ifdef MULU_EARLY_EXIT_EN
        last = (cnt == CW'(WIDTH - 1)) || ((mplr >> 1) == '0);
`else
        last = (cnt == CW'(WIDTH - 1));
`endif
    end

    // NOTE: the datapath registers carry no reset; they are always loaded on
    // start before being used, and busy (which is reset) gates their use.
    always_ff @(posedge clk) begin
        if (start) begin
            acc   <= {{WIDTH{1'b0}}, c};
            mcand <= {{WIDTH{1'b0}}, a};
            mplr  <= b;
            cnt   <= '0;
        end else if (busy) begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
        end
    end

    // Control and outputs. start takes priority over completion, so a start
    // landing on the completion edge suppresses that done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            valid <= 1'b0;
            ovf   <= 1'b0;
            val   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                valid <= 1'b0;
                if (a == '0 || b == '0) begin
                    // Product is zero: result is just the addend.
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    valid <= 1'b1;
                    val   <= {{WIDTH{1'b0}}, c};
                    ovf   <= 1'b0;
                end else begin
                    busy <= 1'b1;
                end
            end else if (busy && last) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                valid <= 1'b1;
                val   <= acc_next;
                ovf   <= |acc_next[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule
